// File: rtl/wb_pkg.sv
// Shared opcode, load-size and state encodings for the write-back stage.
package wb_pkg;

    localparam logic [6:0] OP_LOAD_IMM = 7'b1111111;
    localparam logic [6:0] OP_ALU      = 7'b0110011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_NOP      = 7'b0000000;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Sign/zero-extends a naturally aligned sub-word load to the full data width.
// Latency: combinational. Backpressure: none.
// Reserved size codes (011/110/111) pass the whole word through.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext_data
);

    always_comb begin
        ext_data = mem_rdata;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
            F3_LH:   ext_data = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-back: picks immediate, ALU result or extended load data.
// Latency: 1 cycle after acceptance (imm/ALU) or after mem_rsp_valid (load).
// Backpressure: in_ready low while waiting on a load response or its timeout.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 20,
    parameter int IMM_SHIFT = 0,
    parameter int RA_W      = 5,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        OPCODE,
    input  logic [2:0]        funct3,
    input  logic [RA_W-1:0]   rd,
    input  logic [IMM_W-1:0]  INP,
    input  logic [XLEN-1:0]   ALU_OUT,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wr_en_RF,
    output logic [RA_W-1:0]   wr_addr_RF,
    output logic [XLEN-1:0]   Data_In_RF,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RA_W-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic              wr_en_q, wr_en_d;
    logic [RA_W-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_dat_q, wr_dat_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   load_dat;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .mem_rdata (mem_rdata),
        .funct3    (ld_f3_q),
        .ext_data  (load_dat)
    );

    always_comb begin
        if (IMM_SHIFT != 0) imm_ext = {INP, {(XLEN-IMM_W){1'b0}}};
        else                imm_ext = {{(XLEN-IMM_W){1'b0}}, INP};
    end

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_f3_d   = ld_f3_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (OPCODE)
                        OP_LOAD_IMM: begin
                            wr_en_d   = (rd != '0);
                            wr_addr_d = rd;
                            wr_dat_d  = imm_ext;
                        end
                        OP_ALU: begin
                            wr_en_d   = (rd != '0);
                            wr_addr_d = rd;
                            wr_dat_d  = ALU_OUT;
                        end
                        OP_LOAD: begin
                            ld_rd_d = rd;
                            ld_f3_d = funct3;
                            cnt_d   = '0;
                            state_d = WAIT_MEM;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MEM: begin
                // A response on the last allowed cycle still beats the timeout.
                if (mem_rsp_valid) begin
                    wr_en_d   = (ld_rd_q != '0);
                    wr_addr_d = ld_rd_q;
                    wr_dat_d  = load_dat;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_f3_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_f3_q   <= ld_f3_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
            err_q     <= err_d;
        end
    end

    assign wr_en_RF    = wr_en_q;
    assign wr_addr_RF  = wr_addr_q;
    assign Data_In_RF  = wr_dat_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench: two instances (imm in LSBs / imm in MSBs) against a transaction-level model.
module tb_writeback_unit;

    localparam int TMO = 15;
    localparam logic [6:0] T_LOAD_IMM = 7'b1111111;
    localparam logic [6:0] T_ALU      = 7'b0110011;
    localparam logic [6:0] T_LOAD     = 7'b0000011;
    localparam logic [6:0] T_NOP      = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [19:0] inp;
    logic [31:0] alu_out;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        rdy0, wr_en0, err0;
    logic [4:0]  addr0;
    logic [31:0] dat0;
    logic        rdy1, wr_en1, err1;
    logic [4:0]  addr1;
    logic [31:0] dat1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: values the write port is expected to hold for each instance.
    logic [31:0] exp_dat0, exp_dat1;
    logic [4:0]  exp_addr;

    always #5 clk = ~clk;

    writeback_unit #(.XLEN(32), .IMM_W(20), .IMM_SHIFT(0), .RA_W(5), .TIMEOUT(TMO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .OPCODE(opcode), .funct3(funct3), .rd(rd), .INP(inp), .ALU_OUT(alu_out),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wr_en_RF(wr_en0), .wr_addr_RF(addr0), .Data_In_RF(dat0), .err_timeout(err0)
    );

    writeback_unit #(.XLEN(32), .IMM_W(20), .IMM_SHIFT(1), .RA_W(5), .TIMEOUT(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .OPCODE(opcode), .funct3(funct3), .rd(rd), .INP(inp), .ALU_OUT(alu_out),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .wr_en_RF(wr_en1), .wr_addr_RF(addr1), .Data_In_RF(dat1), .err_timeout(err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0: begin v = w % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'd1: begin v = w % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'd4: v = w % 256;
            3'd5: v = w % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic check_port(input string tag, input logic exp_wr, input logic exp_err);
        check_eq({tag, ".wr_en0"}, 32'(wr_en0), 32'(exp_wr));
        check_eq({tag, ".wr_en1"}, 32'(wr_en1), 32'(exp_wr));
        check_eq({tag, ".err0"},   32'(err0),   32'(exp_err));
        check_eq({tag, ".err1"},   32'(err1),   32'(exp_err));
        check_eq({tag, ".addr0"},  32'(addr0),  32'(exp_addr));
        check_eq({tag, ".addr1"},  32'(addr1),  32'(exp_addr));
        check_eq({tag, ".dat0"},   dat0,        exp_dat0);
        check_eq({tag, ".dat1"},   dat1,        exp_dat1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-load instruction: result visible one cycle after acceptance.
    task automatic issue(input string tag, input logic [6:0] op, input logic [4:0] r,
                         input logic [19:0] imm, input logic [31:0] alu);
        logic is_wr;
        in_valid = 1'b1; opcode = op; rd = r; inp = imm; alu_out = alu;
        funct3 = 3'($urandom);
        check_eq({tag, ".in_ready0"}, 32'(rdy0), 32'd1);
        check_eq({tag, ".in_ready1"}, 32'(rdy1), 32'd1);
        tick();
        in_valid = 1'b0; opcode = T_NOP; rd = 5'($urandom); alu_out = $urandom;
        is_wr = (op == T_LOAD_IMM) || (op == T_ALU);
        if (is_wr) begin
            exp_addr = r;
            exp_dat0 = (op == T_LOAD_IMM) ? {12'd0, imm} : alu;
            exp_dat1 = (op == T_LOAD_IMM) ? {imm, 12'd0} : alu;
        end
        check_port(tag, is_wr && (r != 5'd0), 1'b0);
    endtask

    // Load: `delay` empty cycles in WAIT_MEM before the response; delay >= TMO means none.
    task automatic load(input string tag, input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] rdata, input int delay);
        in_valid = 1'b1; opcode = T_LOAD; funct3 = f3; rd = r;
        check_eq({tag, ".in_ready"}, 32'(rdy0), 32'd1);
        tick();
        in_valid = 1'b0; opcode = T_NOP; funct3 = 3'($urandom); rd = 5'($urandom);
        check_port({tag, ".accept"}, 1'b0, 1'b0);
        check_eq({tag, ".busy"}, 32'(rdy0), 32'd0);
        if (delay < TMO) begin
            for (int i = 0; i < delay; i++) begin
                mem_rdata = $urandom;
                tick();
                check_port({tag, ".wait"}, 1'b0, 1'b0);
                check_eq({tag, ".busy"}, 32'(rdy0), 32'd0);
            end
            mem_rsp_valid = 1'b1; mem_rdata = rdata;
            tick();
            mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            exp_addr = r;
            exp_dat0 = extend(f3, rdata);
            exp_dat1 = exp_dat0;
            check_port({tag, ".rsp"}, r != 5'd0, 1'b0);
        end else begin
            for (int i = 0; i < TMO - 1; i++) begin
                tick();
                check_port({tag, ".wait"}, 1'b0, 1'b0);
                check_eq({tag, ".busy"}, 32'(rdy0), 32'd0);
            end
            tick();
            check_port({tag, ".tmo"}, 1'b0, 1'b1);
            tick();
            check_port({tag, ".post_tmo"}, 1'b0, 1'b0);
        end
        check_eq({tag, ".ready_back"}, 32'(rdy0), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = T_NOP; funct3 = 3'd0; rd = 5'd0;
        inp = 20'd0; alu_out = 32'd0; mem_rsp_valid = 1'b0; mem_rdata = 32'd0;
        exp_dat0 = 32'd0; exp_dat1 = 32'd0; exp_addr = 5'd0;
        tick();
        tick();
        check_port("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("reset.in_ready", 32'(rdy0), 32'd1);

        issue("imm", T_LOAD_IMM, 5'd3, 20'hAAAAA, 32'h0);
        check_eq("imm.lsb_value", dat0, 32'h000AAAAA);
        check_eq("imm.msb_value", dat1, 32'hAAAAA000);

        issue("alu", T_ALU, 5'd5, 20'h0, 32'hDEADBEEF);
        issue("nop", T_NOP, 5'd6, 20'h0, 32'h12345678);
        issue("unk", 7'b1010101, 5'd7, 20'h0, 32'h87654321);
        check_eq("hold.value", dat0, 32'hDEADBEEF);
        issue("alu_rd0", T_ALU, 5'd0, 20'h0, 32'h0BADF00D);

        load("lb", 3'b000, 5'd7, 32'h000000F0, 3);
        check_eq("lb.value", dat0, 32'hFFFFFFF0);
        load("lbu", 3'b100, 5'd7, 32'h000000F0, 3);
        check_eq("lbu.value", dat0, 32'h000000F0);
        load("lh", 3'b001, 5'd7, 32'h00008001, 3);
        check_eq("lh.value", dat0, 32'hFFFF8001);
        load("timeout", 3'b010, 5'd9, 32'h0, TMO);
        load("last_cycle", 3'b010, 5'd9, 32'hCAFEF00D, TMO - 1);
        load("ld_rd0", 3'b010, 5'd0, 32'h55555555, 2);

        // Reset in the middle of a load, then a stray response.
        in_valid = 1'b1; opcode = T_LOAD; funct3 = 3'd2; rd = 5'd4;
        tick();
        in_valid = 1'b0; opcode = T_NOP;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        exp_dat0 = 32'd0; exp_dat1 = 32'd0; exp_addr = 5'd0;
        check_port("mid_reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'h11111111;
        tick();
        check_port("after_reset_rsp", 1'b0, 1'b0);
        check_eq("after_reset.in_ready", 32'(rdy0), 32'd1);
        tick();
        mem_rsp_valid = 1'b0;
        check_port("idle_rsp", 1'b0, 1'b0);
        issue("alu_after_reset", T_ALU, 5'd12, 20'h0, 32'h13572468);

        for (int n = 0; n < 250; n++) begin
            int kind;
            logic [4:0] r;
            kind = $urandom_range(0, 5);
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            case (kind)
                0: issue("rnd_imm", T_LOAD_IMM, r, 20'($urandom), 32'($urandom));
                1: issue("rnd_alu", T_ALU, r, 20'($urandom), 32'($urandom));
                2: begin
                    logic [6:0] op;
                    op = 7'($urandom);
                    if (op == T_LOAD) op = T_NOP;
                    issue("rnd_other", op, r, 20'($urandom), 32'($urandom));
                end
                3: load("rnd_load", 3'($urandom), r, 32'($urandom), $urandom_range(0, TMO + 2));
                4: begin
                    mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
                    tick();
                    mem_rsp_valid = 1'b0;
                    check_port("rnd_idle", 1'b0, 1'b0);
                end
                default: load("rnd_fast", 3'($urandom), r, 32'($urandom), $urandom_range(0, 2));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
